// File: rtl/output_display.sv
// Output register stage: latches the CPU bus on OUT_EN, converts it to decimal with a
// sequential double-dabble engine and multiplexes sign/hundreds/tens/units onto a 4-digit 7-seg display.
module output_display #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus,
    input  logic       out_en,
    input  logic       signed_mode,
    output logic [7:0] out_value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DD_W      = 20;
    localparam logic [3:0]  DIG_DASH  = 4'd10;
    localparam logic [3:0]  DIG_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       bit_cnt;
    logic [DD_W-1:0]  dd;
    logic             sign_r;
    logic [3:0][3:0]  dig;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic             wrap;
    logic             cap_sign;

    // One double-dabble step on {bcd[11:0], mag[7:0]}: correct nibbles >= 5, then shift.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] a;
        a = v;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[DD_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:     g = 7'h3F;
            4'd1:     g = 7'h06;
            4'd2:     g = 7'h5B;
            4'd3:     g = 7'h4F;
            4'd4:     g = 7'h66;
            4'd5:     g = 7'h6D;
            4'd6:     g = 7'h7D;
            4'd7:     g = 7'h07;
            4'd8:     g = 7'h7F;
            4'd9:     g = 7'h6F;
            DIG_DASH: g = 7'h40;
            default:  g = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~g : g;
    endfunction

    assign cap_sign = signed_mode & bus[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // A capture restarts the conversion from any state, so the newest value always wins.
    always_comb begin
        state_next = state;
        if (out_en) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT:   if (bit_cnt == 3'd7) state_next = LOAD;
                LOAD:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_value <= 8'd0;
            busy      <= 1'b0;
            sign_r    <= 1'b0;
            bit_cnt   <= 3'd0;
            dd        <= '0;
            dig       <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};
        end else if (out_en) begin
            out_value <= bus;
            busy      <= 1'b1;
            sign_r    <= cap_sign;
            bit_cnt   <= 3'd0;
            dd        <= {12'd0, cap_sign ? 8'(~bus + 8'd1) : bus};
        end else begin
            case (state)
                SHIFT: begin
                    dd      <= dd_step(dd);
                    bit_cnt <= bit_cnt + 3'd1;
                end
                LOAD: begin
                    busy   <= 1'b0;
                    dig[3] <= sign_r ? DIG_DASH : DIG_BLANK;
                    dig[2] <= (dd[19:16] == 4'd0) ? DIG_BLANK : dd[19:16];
                    dig[1] <= (dd[19:16] == 4'd0 && dd[15:12] == 4'd0) ? DIG_BLANK : dd[15:12];
                    dig[0] <= dd[11:8];
                end
                default: ;
            endcase
        end
    end

    // Refresh mux: an and seg are registered from the same next index so they switch together.
    assign wrap     = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_next = wrap ? idx + 2'd1 : idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            an          <= 4'b1110;
            seg         <= glyph(4'd0);
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + CNT_W'(1);
            idx         <= idx_next;
            an          <= ~(4'b0001 << idx_next);
            seg         <= glyph(dig[idx_next]);
        end
    end

endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display: random and directed captures checked against a
// decimal display model built from integer arithmetic.
module tb_output_display;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] bus;
    logic       out_en;
    logic       signed_mode;
    logic [7:0] out_value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    output_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .out_en     (out_en),
        .signed_mode(signed_mode),
        .out_value  (out_value),
        .busy       (busy),
        .seg        (seg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected seg pattern (active-low) per digit position 3..0 for a captured value.
    function automatic logic [3:0][6:0] model(input logic [7:0] v, input logic sm);
        int n, m, h, t, u;
        logic [3:0][6:0] g;
        n = (sm && v[7]) ? int'(v) - 256 : int'(v);
        m = (n < 0) ? -n : n;
        h = m / 100;
        t = (m / 10) % 10;
        u = m % 10;
        g[3] = (n < 0) ? 7'h40 : 7'h00;
        g[2] = (h == 0) ? 7'h00 : TAB[h];
        g[1] = (h == 0 && t == 0) ? 7'h00 : TAB[t];
        g[0] = TAB[u];
        return ~g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] v, input logic sm);
        bus = v;
        signed_mode = sm;
        out_en = 1'b1;
        step();
        out_en = 1'b0;
        checks++;
        if (out_value !== v || busy !== 1'b1) begin
            failures++;
            $display("FAIL capture: out_value=%h busy=%b expected %h busy=1", out_value, busy, v);
        end
    endtask

    // Counts busy-high samples from the current one; optionally flags a forbidden glyph.
    task automatic wait_done(output int n, input logic chk_forbid, input logic [6:0] forbid);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            if (chk_forbid && seg === forbid) begin
                failures++;
                $display("FAIL stale_glyph: seg=%h shown during conversion", seg);
            end
            n++;
            step();
        end
        if (n >= 60) begin
            failures++;
            $display("FAIL busy_timeout: busy=%b still high after %0d cycles, expected low", busy, n);
        end
    endtask

    task automatic check_busy_len(input string name, input int n, input int exp);
        checks++;
        if (n !== exp) begin
            failures++;
            $display("FAIL %s busy_len: got %0d cycles expected %0d", name, n, exp);
        end
    endtask

    task automatic check_display(input string name, input logic [3:0][6:0] exp);
        int d;
        step();
        for (int k = 0; k < 4 * int'(DIV); k++) begin
            step();
            case (an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            checks++;
            if (d < 0) begin
                failures++;
                $display("FAIL %s an: an=%b not a valid digit enable", name, an);
            end else if (seg !== exp[d]) begin
                failures++;
                $display("FAIL %s digit%0d: seg=%h expected %h", name, d, seg, exp[d]);
            end
        end
    endtask

    task automatic convert(input string name, input logic [7:0] v, input logic sm);
        int n;
        capture(v, sm);
        wait_done(n, 1'b0, 7'h00);
        check_busy_len(name, n, 9);
        check_display(name, model(v, sm));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus = 8'h00;
        out_en = 1'b0;
        signed_mode = 1'b0;
        #12;
        checks++;
        if (out_value !== 8'd0 || busy !== 1'b0 || an !== 4'b1110 || seg !== 7'h40) begin
            failures++;
            $display("FAIL reset: out_value=%h busy=%b an=%b seg=%h expected 00 0 1110 40",
                     out_value, busy, an, seg);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_directed();
        convert("unsigned_123", 8'd123, 1'b0);
        checks++;
        if (out_value !== 8'd123) begin
            failures++;
            $display("FAIL out_value_123: got %h expected 7b", out_value);
        end
        convert("signed_F6", 8'hF6, 1'b1);
        convert("unsigned_F6", 8'hF6, 1'b0);
        convert("signed_80", 8'h80, 1'b1);
        convert("signed_00", 8'h00, 1'b1);
        convert("unsigned_FF", 8'hFF, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic sm;
        for (int i = 0; i < 12; i++) begin
            v = 8'($urandom);
            sm = 1'($urandom);
            convert("random", v, sm);
        end
    endtask

    task automatic test_recapture();
        int n, total;
        convert("pre_zero", 8'd0, 1'b0);
        capture(8'd200, 1'b0);
        total = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy === 1'b1) total++;
        end
        capture(8'd7, 1'b0);
        wait_done(n, 1'b1, ~7'h5B);
        total += n;
        check_busy_len("recapture", total, 13);
        check_display("recapture", model(8'd7, 1'b0));
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] v [3];
        for (int i = 0; i < 3; i++) v[i] = 8'($urandom);
        out_en = 1'b1;
        signed_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus = v[i];
            step();
        end
        out_en = 1'b0;
        wait_done(n, 1'b0, 7'h00);
        check_busy_len("back_to_back", n, 9);
        checks++;
        if (out_value !== v[2]) begin
            failures++;
            $display("FAIL back_to_back out_value: got %h expected %h", out_value, v[2]);
        end
        check_display("back_to_back", model(v[2], 1'b1));
    endtask

    task automatic test_mux_and_reset();
        logic [3:0] exp_an;
        capture(8'd99, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_value !== 8'd0 || an !== 4'b1110 || seg !== 7'h40) begin
            failures++;
            $display("FAIL reset_midshift: busy=%b out_value=%h an=%b seg=%h expected 0 00 1110 40",
                     busy, out_value, an, seg);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 32; k++) begin
            exp_an = ~(4'b0001 << ((k / int'(DIV)) % 4));
            checks++;
            if (an !== exp_an) begin
                failures++;
                $display("FAIL mux_seq k=%0d: an=%b expected %b", k, an, exp_an);
            end
            if (k < 31) step();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
        check_display("after_reset", model(8'd0, 1'b0));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_recapture();
        test_back_to_back();
        test_mux_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
